// File: rtl/id_ex_stage_reg_if.sv
// Signal bundle between the ID/WB side and the ID/EX stage register.
// The stage itself connects through the slave modport.
interface id_ex_stage_reg_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  logic                  stall;
  logic                  flush;
  logic                  id_valid;
  logic [3:0]            id_opcode;
  logic [DATA_W-1:0]     id_pc;
  logic [DATA_W-1:0]     id_imm;
  logic [REG_ADDR_W-1:0] id_src_reg1;
  logic [REG_ADDR_W-1:0] id_src_reg2;
  logic [DATA_W-1:0]     id_src_data1;
  logic [DATA_W-1:0]     id_src_data2;
  logic [REG_ADDR_W-1:0] id_dst_reg;
  logic                  id_write_reg;
  logic                  wb_write_reg;
  logic [REG_ADDR_W-1:0] wb_dst_reg;
  logic [DATA_W-1:0]     wb_dst_data;
  logic                  ex_valid;
  logic [3:0]            ex_opcode;
  logic [DATA_W-1:0]     ex_pc;
  logic [DATA_W-1:0]     ex_imm;
  logic [REG_ADDR_W-1:0] ex_src_reg1;
  logic [REG_ADDR_W-1:0] ex_src_reg2;
  logic [DATA_W-1:0]     ex_src_data1;
  logic [DATA_W-1:0]     ex_src_data2;
  logic [REG_ADDR_W-1:0] ex_dst_reg;
  logic                  ex_write_reg;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output stall, flush, id_valid, id_opcode, id_pc, id_imm, id_src_reg1, id_src_reg2,
           id_src_data1, id_src_data2, id_dst_reg, id_write_reg,
           wb_write_reg, wb_dst_reg, wb_dst_data,
    input  ex_valid, ex_opcode, ex_pc, ex_imm, ex_src_reg1, ex_src_reg2,
           ex_src_data1, ex_src_data2, ex_dst_reg, ex_write_reg, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_opcode, id_pc, id_imm, id_src_reg1, id_src_reg2,
           id_src_data1, id_src_data2, id_dst_reg, id_write_reg,
           wb_write_reg, wb_dst_reg, wb_dst_data,
    output ex_valid, ex_opcode, ex_pc, ex_imm, ex_src_reg1, ex_src_reg2,
           ex_src_data1, ex_src_data2, ex_dst_reg, ex_write_reg, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall/flush, WB write-through bypass on load,
// WB refresh of held operands while stalled, and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  id_ex_stage_reg_if.slave bus
);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // r0 reads as zero; a non-zero source matching the WB port takes the WB data.
  function automatic logic [DATA_W-1:0] f_sel_operand(
    input logic [REG_ADDR_W-1:0] src,
    input logic [DATA_W-1:0]     rf_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_dst,
    input logic [DATA_W-1:0]     wb_data
  );
    logic [DATA_W-1:0] result;
    if (src == REG_ZERO) begin
      result = DATA_ZERO;
    end else if (wb_we && (wb_dst == src)) begin
      result = wb_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  function automatic logic f_refresh(
    input logic                  valid,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_dst
  );
    return valid && wb_we && (wb_dst == src) && (src != REG_ZERO);
  endfunction

  logic                  r_ex_valid;
  logic [3:0]            r_ex_opcode;
  logic [DATA_W-1:0]     r_ex_pc;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [REG_ADDR_W-1:0] r_ex_src_reg1;
  logic [REG_ADDR_W-1:0] r_ex_src_reg2;
  logic [DATA_W-1:0]     r_ex_src_data1;
  logic [DATA_W-1:0]     r_ex_src_data2;
  logic [REG_ADDR_W-1:0] r_ex_dst_reg;
  logic                  r_ex_write_reg;
  logic [CNT_W-1:0]      r_bubble_cnt;

  logic [DATA_W-1:0]     w_op1;
  logic [DATA_W-1:0]     w_op2;
  logic                  w_refresh1;
  logic                  w_refresh2;
  logic                  w_ld_write;
  logic                  w_bubble;

  // Operand selection, refresh qualification and bubble detection for this edge.
  always_comb begin
    w_op1      = f_sel_operand(bus.id_src_reg1, bus.id_src_data1,
                               bus.wb_write_reg, bus.wb_dst_reg, bus.wb_dst_data);
    w_op2      = f_sel_operand(bus.id_src_reg2, bus.id_src_data2,
                               bus.wb_write_reg, bus.wb_dst_reg, bus.wb_dst_data);
    w_refresh1 = f_refresh(r_ex_valid, r_ex_src_reg1, bus.wb_write_reg, bus.wb_dst_reg);
    w_refresh2 = f_refresh(r_ex_valid, r_ex_src_reg2, bus.wb_write_reg, bus.wb_dst_reg);
    w_ld_write = bus.id_valid && bus.id_write_reg && (bus.id_dst_reg != REG_ZERO);
    w_bubble   = bus.flush || (!bus.stall && !bus.id_valid);
  end

  // EX-side fields: reset > flush > stall (refresh only) > load.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_ex_valid     <= 1'b0;
      r_ex_opcode    <= 4'h0;
      r_ex_pc        <= DATA_ZERO;
      r_ex_imm       <= DATA_ZERO;
      r_ex_src_reg1  <= REG_ZERO;
      r_ex_src_reg2  <= REG_ZERO;
      r_ex_src_data1 <= DATA_ZERO;
      r_ex_src_data2 <= DATA_ZERO;
      r_ex_dst_reg   <= REG_ZERO;
      r_ex_write_reg <= 1'b0;
    end else if (bus.stall) begin
      if (w_refresh1) r_ex_src_data1 <= bus.wb_dst_data;
      if (w_refresh2) r_ex_src_data2 <= bus.wb_dst_data;
    end else begin
      r_ex_valid     <= bus.id_valid;
      r_ex_opcode    <= bus.id_opcode;
      r_ex_pc        <= bus.id_pc;
      r_ex_imm       <= bus.id_imm;
      r_ex_src_reg1  <= bus.id_src_reg1;
      r_ex_src_reg2  <= bus.id_src_reg2;
      r_ex_src_data1 <= w_op1;
      r_ex_src_data2 <= w_op2;
      r_ex_dst_reg   <= bus.id_dst_reg;
      r_ex_write_reg <= w_ld_write;
    end
  end

  // Saturating count of edges that leave a bubble in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= CNT_ZERO;
    end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_opcode    = r_ex_opcode;
  assign bus.ex_pc        = r_ex_pc;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.ex_src_reg1  = r_ex_src_reg1;
  assign bus.ex_src_reg2  = r_ex_src_reg2;
  assign bus.ex_src_data1 = r_ex_src_data1;
  assign bus.ex_src_data2 = r_ex_src_data2;
  assign bus.ex_dst_reg   = r_ex_dst_reg;
  assign bus.ex_write_reg = r_ex_write_reg;
  assign bus.bubble_cnt   = r_bubble_cnt;
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline stage register placed directly downstream of the 16x16 register file.
- Latches the decoded instruction fields and the two register-file read operands for the EX stage.
- Supports stall (hold) and flush (bubble).
- Write-through bypass from the WB write port covers the same-cycle write/read case. Also refreshes held operands while stalled.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_ADDR_W, 4, register specifier width (16 registers; r0 hard-wired zero)
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all EX-side state this cycle
- flush  in  1  insert bubble into EX this cycle
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  4  decoded opcode
- id_pc  in  DATA_W  PC of ID instruction
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_src_reg1, id_src_reg2  in  REG_ADDR_W  source specifiers (also drive register file read ports)
- id_src_data1, id_src_data2  in  DATA_W  register-file read data
- id_dst_reg  in  REG_ADDR_W  destination specifier
- id_write_reg  in  1  instruction writes a register
- wb_write_reg  in  1  WB write enable (same net as register-file write_reg)
- wb_dst_reg  in  REG_ADDR_W  WB destination (same net as register-file dst_reg)
- wb_dst_data  in  DATA_W  WB data (same net as register-file dst_data)
- ex_valid  out  1  EX holds a real instruction
- ex_opcode, ex_pc, ex_imm, ex_src_reg1, ex_src_reg2, ex_src_data1, ex_src_data2, ex_dst_reg  out  (widths as ID counterparts)  latched fields
- ex_write_reg  out  1  qualified write enable for EX instruction
- bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Update priority each edge: rst > flush > stall > load.
- Reset: every output is 0, including ex_valid, ex_write_reg, all fields and bubble_cnt.
- Load (no rst/flush/stall): all ex_* fields take their id_* values on the edge. Latency is 1 cycle.
  - ex_valid <= id_valid.
  - ex_write_reg <= id_valid & id_write_reg & (id_dst_reg != 0).
- Operand select on load, N = 1, 2:
  - if id_src_regN == 0: capture 0, regardless of id_src_dataN.
  - else if wb_write_reg && wb_dst_reg == id_src_regN && wb_dst_reg != 0: capture wb_dst_data (bypass).
  - else: capture id_src_dataN.
  - Both operands may bypass in the same cycle when src1 == src2.
- Stall (no flush): all fields hold, with one exception.
  - If ex_valid && wb_write_reg && wb_dst_reg == ex_src_regN && ex_src_regN != 0, then ex_src_dataN <= wb_dst_data (refresh).
  - Nothing else changes.
- Flush: ex_valid <= 0 and ex_write_reg <= 0. Other fields are cleared to 0. Flush overrides a simultaneous stall.
- bubble_cnt:
  - Increments by 1 on any non-reset edge where the new ex_valid is 0, i.e. on flush, or on load with id_valid = 0.
  - A stall holding a bubble does not count.
  - Saturates at all-ones and does not wrap.
- No combinational path from any input to any output; all outputs are registered.
- Reset asserted mid-stall or mid-flush clears state on that edge. The first load after reset deassertion is a normal load.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> all outputs 0. Deassert; next load with id_valid=1, id_pc=16'h0040 -> ex_pc=16'h0040, ex_valid=1 one cycle later.
- Bypass: id_src_reg1=3, id_src_data1=16'h1111; wb_write_reg=1, wb_dst_reg=3, wb_dst_data=16'hBEEF -> ex_src_data1=16'hBEEF. Same stimulus with wb_dst_reg=4 -> 16'h1111.
- r0 rule: id_src_reg2=0, id_src_data2=16'hFFFF, wb writes r0 with 16'h1234 -> ex_src_data2=0. id_dst_reg=0, id_write_reg=1 -> ex_write_reg=0.
- Stall refresh: load ex_src_reg2=5 with data 16'h0007; hold stall=1 for 3 cycles, WB writes r5=16'h00A0 in cycle 2 -> ex_src_data2=16'h00A0, all other fields unchanged, bubble_cnt unchanged.
- Flush vs stall: stall=1 and flush=1 together on a valid EX instruction -> ex_valid=0, ex_write_reg=0, bubble_cnt +1.
- Counter saturation: with CNT_W=4, apply 20 consecutive id_valid=0 loads -> bubble_cnt stops at 4'hF.
